branch_target_buffer: RTL and testbench
=======================================

// Module: branch_target_buffer
// PURPOSE
//  Direct-mapped branch target buffer (BTB) in the fetch stage, upstream of the
//  2-bit direction predictor. Fetch PC is looked up each cycle. The BTB supplies:
//  - hit: PC is a known BEQ/BNE;
//  - target: the stored branch target;
//  - prindex: the predictor index.
//  The fetch mux redirects when btb_hit & PRresult.
//  The BTB is written at branch resolution (EX/MEM) from the same opfunc/ABtaken
//  signals that train the predictor.
// PARAMETERS
//  ENTRIES  4   number of BTB lines; power of 2; must equal predictor table size
//  IDX_W    2   log2(ENTRIES); index = pc[IDX_W+1:2]
//  TAG_W    28  tag = pc[31:IDX_W+2] (32 - IDX_W - 2)
// PORTS
//  CLK         in   1      clock; all state updates on posedge
//  nRST        in   1      asynchronous, active-low reset
//  pcif        in   32     fetch-stage PC (word aligned)
//  btb_hit     out  1      valid entry with matching tag for pcif
//  btb_target  out  32     stored target (32'h0 when !btb_hit)
//  prindex     out  IDX_W  pcif[IDX_W+1:2]; drives predictor prindex
//  upd_pc      in   32     PC of the resolving branch
//  upd_target  in   32     computed branch target of the resolving branch
//  opfunc      in   opfunc_t  resolving instruction op; update only for OBEQ/OBNE
//  ABtaken     in   1      actual outcome of the resolving branch
//  upd_stall   in   1      pipeline stall; blocks all updates while high
//  btb_flush   in   1      synchronous invalidate-all (e.g. on halt)
// BEHAVIOUR
//  - Reset (nRST=0, async): all valid bits=0, tags/targets=0. Outputs follow
//    combinationally: btb_hit=0, btb_target=0.
//  - Lookup is combinational, with zero-cycle latency.
//    idx=pcif[IDX_W+1:2]; hit = valid[idx] & (tag[idx]==pcif[31:IDX_W+2]).
//  - Update qualifier: upd = (opfunc==OBEQ | opfunc==OBNE) & !upd_stall.
//  - Taken update (upd & ABtaken): write line uidx=upd_pc[IDX_W+1:2] with
//    valid=1, tag=upd_pc tag, target=upd_target. This overwrites any prior
//    occupant (direct-mapped, no replacement state).
//  - Not-taken update (upd & !ABtaken): the line is left unchanged. Direction is
//    owned by the predictor; the entry is never deallocated on not-taken.
//  - Same-cycle write/read bypass: if upd & ABtaken, uidx==idx and the tags match,
//    then btb_hit=1 and btb_target=upd_target in that same cycle. No bubble is
//    allowed on a tight loop.
//  - btb_flush: on the next posedge all valid bits=0. Flush has priority over a
//    simultaneous update; the update is dropped. The bypass is suppressed while
//    btb_flush=1.
//  - Aliasing: two branches with equal index but different tags evict each
//    other. Stale target use is impossible because the tag is compared in full.
//  - Mid-operation reset clears the valid bits immediately, regardless of clock.
//  - pcif[1:0] and upd_pc[1:0] are ignored.
// STRUCTURE
//  - Shared package (cpu_types_pkg): typedef struct packed {logic valid;
//    logic [TAG_W-1:0] tag; word_t target;} btb_entry_t. opfunc_t, OBEQ and OBNE
//    stay in control_unit_types_pkg.
//  - No sub-module. Use one always_ff with async reset on the btb_entry_t array,
//    one always_comb lookup with bypass, and one assign for prindex.
//  - prindex and predictor update index come from identical bit slices, so BTB
//    line i and predictor counter i always describe the same branch.
// TESTING
//  1. Reset: nRST=0 mid-cycle, pcif=32'h40 -> btb_hit=0 and btb_target=0 at once.
//     After release all lookups miss.
//  2. Allocate: opfunc=OBEQ, ABtaken=1, upd_pc=32'h40, upd_target=32'h80 ->
//     next cycle pcif=32'h40 gives hit=1, target=32'h80, prindex=2'b00.
//  3. Bypass: the same update while pcif=32'h40 in the same cycle -> hit=1 and
//     target=32'h80 in that cycle.
//  4. Alias: allocate 32'h40->80, then upd_pc=32'h50 (same idx 00) -> 32'hC0.
//     pcif=32'h40 then misses; pcif=32'h50 hits with target 32'hC0.
//  5. Qualifiers: ABtaken=0; or opfunc=OADD with ABtaken=1; or upd_stall=1 ->
//     no line changes; a previously allocated line is still a hit.
//  6. Flush priority: btb_flush=1 with a concurrent taken update to 32'h60 ->
//     bypass hit=0 that cycle; afterwards all lookups, including 32'h60, miss.

Source files
------------

// File: rtl/control_unit_types_pkg.sv
// Decoded instruction operation codes shared by control and fetch logic.
package control_unit_types_pkg;
  typedef enum logic [3:0] {
    OADD  = 4'd0,
    OSUB  = 4'd1,
    OAND  = 4'd2,
    OOR   = 4'd3,
    OBEQ  = 4'd4,
    OBNE  = 4'd5,
    OJ    = 4'd6,
    OHALT = 4'd7
  } opfunc_t;
endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and the BTB line format.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  localparam int BTB_ENTRIES = 4;
  localparam int BTB_IDX_W   = 2;
  localparam int BTB_TAG_W   = 32 - BTB_IDX_W - 2;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    word_t                target;
  } btb_entry_t;
endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: combinational lookup of the fetch PC,
// written at branch resolution, with same-cycle write/read bypass.
module branch_target_buffer
  import cpu_types_pkg::*;
  import control_unit_types_pkg::*;
#(
  parameter int ENTRIES = BTB_ENTRIES,
  parameter int IDX_W   = BTB_IDX_W
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [31:0]      pcif,
  output logic             btb_hit,
  output logic [31:0]      btb_target,
  output logic [IDX_W-1:0] prindex,
  input  logic [31:0]      upd_pc,
  input  logic [31:0]      upd_target,
  input  opfunc_t          opfunc,
  input  logic             ABtaken,
  input  logic             upd_stall,
  input  logic             btb_flush
);
  localparam int TAG_W = 32 - IDX_W - 2;

  btb_entry_t       btb_q [ENTRIES];
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] uidx;
  logic [TAG_W-1:0] tag_in;
  logic [TAG_W-1:0] utag;
  logic             upd_taken;

  assign idx    = pcif[IDX_W+1:2];
  assign tag_in = pcif[31:IDX_W+2];
  assign uidx   = upd_pc[IDX_W+1:2];
  assign utag   = upd_pc[31:IDX_W+2];

  // Not-taken branches never touch the line; direction lives in the predictor.
  assign upd_taken = ((opfunc == OBEQ) || (opfunc == OBNE)) && !upd_stall && ABtaken;

  // Same slice as the predictor's update index, keeping line i and counter i paired.
  assign prindex = idx;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) btb_q[i] <= '0;
    end else if (btb_flush) begin
      for (int i = 0; i < ENTRIES; i++) btb_q[i].valid <= 1'b0;
    end else if (upd_taken) begin
      btb_q[uidx] <= '{valid: 1'b1, tag: utag, target: upd_target};
    end
  end

  always_comb begin
    btb_hit    = 1'b0;
    btb_target = '0;
    if (upd_taken && !btb_flush && (uidx == idx) && (utag == tag_in)) begin
      btb_hit    = 1'b1;
      btb_target = upd_target;
    end else if (btb_q[idx].valid && (btb_q[idx].tag == tag_in)) begin
      btb_hit    = 1'b1;
      btb_target = btb_q[idx].target;
    end
  end
endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: directed lookups queue their
// expected response, a monitor process pops and compares against the DUT.
module tb_branch_target_buffer;
  import cpu_types_pkg::*;
  import control_unit_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] pcif;
  logic        btb_hit;
  logic [31:0] btb_target;
  logic [1:0]  prindex;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  opfunc_t     opfunc;
  logic        ABtaken;
  logic        upd_stall;
  logic        btb_flush;

  branch_target_buffer dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .pcif       (pcif),
    .btb_hit    (btb_hit),
    .btb_target (btb_target),
    .prindex    (prindex),
    .upd_pc     (upd_pc),
    .upd_target (upd_target),
    .opfunc     (opfunc),
    .ABtaken    (ABtaken),
    .upd_stall  (upd_stall),
    .btb_flush  (btb_flush)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic        hit;
    logic [31:0] tgt;
    logic [1:0]  pidx;
  } exp_t;

  exp_t exp_q[$];
  int   pushed   = 0;
  int   popped   = 0;
  int   compared = 0;
  int   mismatched = 0;

  always begin
    exp_t e;
    wait (pushed != popped);
    e = exp_q.pop_front();
    popped++;
    compared++;
    if (btb_hit !== e.hit || btb_target !== e.tgt || prindex !== e.pidx) begin
      mismatched++;
      $display("FAIL %s: got hit=%b target=%h prindex=%b, want hit=%b target=%h prindex=%b",
               e.name, btb_hit, btb_target, prindex, e.hit, e.tgt, e.pidx);
    end
  end

  task automatic idle();
    opfunc = OADD; ABtaken = 1'b0; upd_stall = 1'b0; btb_flush = 1'b0;
    upd_pc = 32'h0; upd_target = 32'h0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic update(input opfunc_t op, input logic taken,
                        input logic [31:0] pc, input logic [31:0] tgt);
    opfunc = op; ABtaken = taken; upd_pc = pc; upd_target = tgt;
  endtask

  task automatic look(input string name, input logic [31:0] pc,
                      input logic hit, input logic [31:0] tgt, input logic [1:0] pidx);
    exp_t e;
    pcif = pc;
    #1;
    e.name = name; e.hit = hit; e.tgt = tgt; e.pidx = pidx;
    exp_q.push_back(e);
    pushed++;
    #0;
  endtask

  initial begin
    nRST = 1'b0; pcif = 32'h40; idle();
    #2;
    look("reset_hold_40", 32'h40, 1'b0, 32'h0, 2'b00);
    tick();
    nRST = 1'b1;
    tick();
    look("post_reset_40", 32'h40, 1'b0, 32'h0, 2'b00);
    look("post_reset_58", 32'h58, 1'b0, 32'h0, 2'b10);

    // Allocate 40->80, lookup elsewhere during the write so no bypass applies.
    update(OBEQ, 1'b1, 32'h40, 32'h80);
    look("alloc_other_pc", 32'h0, 1'b0, 32'h0, 2'b00);
    tick(); idle();
    look("alloc_hit_40", 32'h40, 1'b1, 32'h80, 2'b00);

    // Asynchronous reset in the middle of a cycle.
    #2; nRST = 1'b0;
    look("async_reset_40", 32'h40, 1'b0, 32'h0, 2'b00);
    tick(); nRST = 1'b1; tick();
    look("after_async_reset_40", 32'h40, 1'b0, 32'h0, 2'b00);

    // Bypass on an empty line.
    update(OBEQ, 1'b1, 32'h40, 32'h80);
    look("bypass_40", 32'h40, 1'b1, 32'h80, 2'b00);
    tick(); idle();
    look("bypass_stored_40", 32'h40, 1'b1, 32'h80, 2'b00);

    // Alias at index 0 evicts 0x40.
    update(OBNE, 1'b1, 32'h50, 32'hC0);
    tick(); idle();
    look("alias_miss_40", 32'h40, 1'b0, 32'h0, 2'b00);
    look("alias_hit_50", 32'h50, 1'b1, 32'hC0, 2'b00);

    // Qualifiers, on line 1 holding 0x44->0x100.
    update(OBEQ, 1'b1, 32'h44, 32'h100);
    tick(); idle();
    look("q_alloc_44", 32'h44, 1'b1, 32'h100, 2'b01);
    update(OBEQ, 1'b0, 32'h44, 32'h200);
    tick(); idle();
    look("q_nottaken_same", 32'h44, 1'b1, 32'h100, 2'b01);
    update(OBNE, 1'b0, 32'h54, 32'h200);
    tick(); idle();
    look("q_nottaken_alias", 32'h44, 1'b1, 32'h100, 2'b01);
    update(OADD, 1'b1, 32'h54, 32'h300);
    look("q_nonbranch_nobypass", 32'h54, 1'b0, 32'h0, 2'b01);
    tick(); idle();
    look("q_nonbranch_54", 32'h54, 1'b0, 32'h0, 2'b01);
    look("q_nonbranch_44", 32'h44, 1'b1, 32'h100, 2'b01);
    update(OBEQ, 1'b1, 32'h54, 32'h300); upd_stall = 1'b1;
    look("q_stall_nobypass", 32'h54, 1'b0, 32'h0, 2'b01);
    tick(); idle();
    look("q_stall_54", 32'h54, 1'b0, 32'h0, 2'b01);
    look("q_stall_44", 32'h44, 1'b1, 32'h100, 2'b01);

    // Flush priority over a concurrent taken update.
    update(OBEQ, 1'b1, 32'h68, 32'h500);
    tick(); idle();
    look("f_alloc_68", 32'h68, 1'b1, 32'h500, 2'b10);
    update(OBEQ, 1'b1, 32'h60, 32'h600); btb_flush = 1'b1;
    look("f_bypass_suppressed", 32'h60, 1'b0, 32'h0, 2'b00);
    tick(); idle();
    look("f_miss_60", 32'h60, 1'b0, 32'h0, 2'b00);
    look("f_miss_68", 32'h68, 1'b0, 32'h0, 2'b10);
    look("f_miss_44", 32'h44, 1'b0, 32'h0, 2'b01);
    look("f_miss_50", 32'h50, 1'b0, 32'h0, 2'b00);

    // Refill after flush on line 3; low PC bits ignored on both sides.
    update(OBNE, 1'b1, 32'h4E, 32'h700);
    tick(); idle();
    look("refill_4c", 32'h4D, 1'b1, 32'h700, 2'b11);

    #5;
    compared++;
    if (pushed != popped) begin
      mismatched++;
      $display("FAIL scoreboard_drain: popped %0d, pushed %0d", popped, pushed);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
